// File: rtl/mips_alu_mdu.sv
// mips_alu_mdu: registered ALU with iterative MULTU/DIVU and HI/LO.
// Define ALU_OVF_EN to enable signed ADD/SUB overflow detection.
module mips_alu_mdu #(
   parameter int WIDTH = 32,
   parameter int CTL_W = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CTL_W-1:0] ALUCtl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUOut,
   output logic             Zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy,
   output logic             Overflow,
   output logic             Fault
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [CTL_W-1:0] OP_AND   = CTL_W'(0);
   localparam logic [CTL_W-1:0] OP_OR    = CTL_W'(1);
   localparam logic [CTL_W-1:0] OP_ADD   = CTL_W'(2);
   localparam logic [CTL_W-1:0] OP_MULTU = CTL_W'(3);
   localparam logic [CTL_W-1:0] OP_DIVU  = CTL_W'(4);
   localparam logic [CTL_W-1:0] OP_SLTU  = CTL_W'(5);
   localparam logic [CTL_W-1:0] OP_SUB   = CTL_W'(6);
   localparam logic [CTL_W-1:0] OP_SLT   = CTL_W'(7);
   localparam logic [CTL_W-1:0] OP_MFHI  = CTL_W'(8);
   localparam logic [CTL_W-1:0] OP_MFLO  = CTL_W'(9);
   localparam logic [CTL_W-1:0] OP_NOR   = CTL_W'(12);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]   out_q, hi_q, lo_q;
   logic               vld_q, zero_q, fault_q;
   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0]   opnd;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     mul_sum, div_dif;
   logic [WIDTH-1:0]   sum_c, dif_c, res_c;
   logic               unk_c;
   logic               accept, start_mul, start_div;
   logic               start_it, div_zero, last, done;

   assign in_ready = RESET && (state == S_IDLE)
                   && (!vld_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign div_zero  = (ALUCtl == OP_DIVU) && (B == '0);
   assign start_mul = accept && (ALUCtl == OP_MULTU);
   assign start_div = accept && (ALUCtl == OP_DIVU) && !div_zero;
   assign start_it  = start_mul || start_div;
   assign busy      = (state != S_IDLE);
   assign last      = (cnt == CNT_W'(WIDTH - 1));
   assign done      = busy && last;

   assign out_valid = vld_q;
   assign ALUOut    = out_q;
   assign Zero      = zero_q;
   assign HI        = hi_q;
   assign LO        = lo_q;
   assign Fault     = fault_q;

   assign sum_c = A + B;
   assign dif_c = A - B;

   always_comb begin
      res_c = '0;
      unk_c = 1'b0;
      unique case (ALUCtl)
         OP_AND:  res_c = A & B;
         OP_OR:   res_c = A | B;
         OP_ADD:  res_c = sum_c;
         OP_SUB:  res_c = dif_c;
         OP_SLT:  res_c = {{(WIDTH-1){1'b0}},
                           ($signed(A) < $signed(B))};
         OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (A < B)};
         OP_NOR:  res_c = ~(A | B);
         OP_MFHI: res_c = hi_q;
         OP_MFLO: res_c = lo_q;
         OP_MULTU, OP_DIVU: res_c = '0;
         default: unk_c = 1'b1;
      endcase
   end

   // acc holds {partial, multiplier} for MUL, {remainder, quotient} for DIV
   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      div_dif = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
      acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
      if (state == S_MUL)
         acc_nxt = {mul_sum, acc[WIDTH-1:1]};
      else if (!div_dif[WIDTH])
         acc_nxt = {div_dif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (start_mul)      state_nxt = S_MUL;
            else if (start_div) state_nxt = S_DIV;
         end
         S_MUL, S_DIV: begin
            if (last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state   <= S_IDLE;
         vld_q   <= 1'b0;
         out_q   <= '0;
         zero_q  <= 1'b1;
         fault_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         acc     <= '0;
         opnd    <= '0;
         cnt     <= '0;
      end else begin
         state <= state_nxt;
         if (busy) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
               hi_q    <= acc_nxt[2*WIDTH-1:WIDTH];
               lo_q    <= acc_nxt[WIDTH-1:0];
               out_q   <= acc_nxt[WIDTH-1:0];
               zero_q  <= (acc_nxt[WIDTH-1:0] == '0);
               fault_q <= 1'b0;
               vld_q   <= 1'b1;
            end
         end else if (accept) begin
            if (start_it) begin
               vld_q <= 1'b0;
               cnt   <= '0;
               opnd  <= start_mul ? A : B;
               acc   <= {{WIDTH{1'b0}}, start_mul ? B : A};
            end else if (div_zero) begin
               lo_q    <= '1;
               hi_q    <= A;
               out_q   <= '1;
               zero_q  <= 1'b0;
               fault_q <= 1'b1;
               vld_q   <= 1'b1;
            end else begin
               out_q   <= res_c;
               zero_q  <= (res_c == '0);
               fault_q <= unk_c;
               vld_q   <= 1'b1;
            end
         end else if (vld_q && out_ready) begin
            vld_q <= 1'b0;
         end
      end
   end

`ifdef ALU_OVF_EN
   logic ovf_c, ovf_q;

   always_comb begin
      ovf_c = 1'b0;
      if (ALUCtl == OP_ADD)
         ovf_c = (A[WIDTH-1] == B[WIDTH-1])
              && (sum_c[WIDTH-1] != A[WIDTH-1]);
      else if (ALUCtl == OP_SUB)
         ovf_c = (A[WIDTH-1] != B[WIDTH-1])
              && (dif_c[WIDTH-1] != A[WIDTH-1]);
   end

   always_ff @(posedge CLK) begin
      if (!RESET)
         ovf_q <= 1'b0;
      else if (accept && !start_it)
         ovf_q <= ovf_c;
      else if (done)
         ovf_q <= 1'b0;
   end

   assign Overflow = ovf_q;
`else
   assign Overflow = 1'b0;
`endif

endmodule
